encode_vector: RTL and testbench
================================

Name: encode_vector

Overview:
- Serialises one decoded vector instruction record into the ISA dword stream: VOP1, VOP2, VOPC, VINTRP, VOP3, VOP3P, plus their SDWA, DPP and literal extensions.
- Mirror of the vector decode path.
- Used by the instruction-injection and test-program generation paths.
- Accepts a `vector_inst_t` over a valid/ready handshake and emits 1–3 registered 32-bit words over a second valid/ready handshake, with a last-word flag.

Parameters:
None. All widths are fixed by the ISA encoding.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_inst  input  vector_inst_t  decoded instruction record to encode
- in_vop3b  input  1  VOP3 word0 bits[14:8] take sdst (1) or {op_sel,abs} (0); ignored for other formats
- in_valid  input  1  in_inst/in_vop3b valid
- in_ready  output  1  record accepted when in_valid & in_ready
- out_data  output  32  current instruction dword
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer takes word when out_valid & out_ready
- out_last  output  1  out_data is the final dword of the instruction
- busy  output  1  an instruction is latched and not fully emitted

Behaviour:
- Reset values: out_valid=0, out_last=0, out_data=0, busy=0, state=E_IDLE, latched record=0. Reset mid-instruction discards remaining words with no partial output afterwards.
- States: E_IDLE, E_WORD0, E_WORD1, E_SDWA, E_DPP, E_LITERAL. out_valid=1 in every state except E_IDLE.
- in_ready = (state==E_IDLE) | (out_valid & out_ready & out_last). This gives back-to-back instructions with no bubble.
- On accept: latch the record, go to E_WORD0, and present word0 the next cycle (latency 1).
- Words advance only on out_valid & out_ready. out_data and out_last stay stable while out_ready=0.
- Transition from E_WORD0:
  - VOP3/VOP3P -> E_WORD1.
  - VOP1/VOP2/VOPC, first matching rule:
    - src0==SDWA -> E_SDWA
    - src0 in {DPP16, DPP8, DPP8FI} -> E_DPP
    - src0=={0,LITERAL_CONSTANT} or (VOP2 & op==V_FMAMK_F32) -> E_LITERAL
  - Otherwise last. VINTRP is always last.
- E_WORD1: if any of src0/src1/src2=={0,LITERAL_CONSTANT} -> E_LITERAL, else last. E_SDWA, E_DPP and E_LITERAL are always last.
- After the last word is taken: go to E_WORD0 if a new record is accepted in the same cycle, else E_IDLE.
- Word0 layouts (MSB first):
  - VOP2: {0, op[5:0], vdst[7:0], src1[7:0], src0[8:0]}
  - VOP1: {7'b0111111, vdst, op[7:0], src0}
  - VOPC: {7'b0111110, op[7:0], src1[7:0], src0}
  - VINTRP: {6'b110010, vdst, op[1:0], attr[5:0], attr_chan[1:0], src0[7:0]}
  - VOP3: {6'b110101, op[9:0], clmp, in_vop3b ? sdst[6:0] : {op_sel[3:0], abs[2:0]}, vdst}
  - VOP3P: {6'b110011, 3'b000, op[6:0], clmp, op_sel_hi[2], op_sel[2:0], neg_hi[2:0], vdst}
- Word1 (VOP3/VOP3P): {neg[2:0], (VOP3 ? omod : op_sel_hi[1:0]), src2, src1, src0}.
- SDWA word:
  - [31]=s1, [30]=0, [29:27]={src1_abs, src1_neg, src1_sext}, [26:24]=src1_sel, [23]=s0, [22]=0, [21:19]={src0_abs, src0_neg, src0_sext}, [18:16]=src0_sel.
  - [15:8]: VOPC uses {sd, sdst[6:0]}; other formats use {omod, clmp, dst_u, dst_sel}.
  - [7:0]=sdwa.src0.
- DPP word:
  - [7:0]=dpp.src0.
  - When word0 src0==DPP16: {row_mask, bank_mask, src1_abs, src1_neg, src0_abs, src0_neg, bc, fi, 1'b0, dpp_ctrl[8:0]}.
  - Otherwise: {lane_sel7..lane_sel0}.
- Literal word = in_inst.literal.
- Unused or unrecognised format latched: emit word0 only, as the VOP1 layout, with out_last=1.
- busy = state!=E_IDLE.

Decomposition:
- vector_op_pkg gains encoding constants: VOP1_PREFIX (7'b0111111), VOPC_PREFIX (7'b0111110), VINTRP_ENC, VOP3_ENC, VOP3P_ENC (6-bit).
- Add an `enc_word_e` word-kind enum to vector_op_pkg.
- LITERAL_CONSTANT, SDWA, DPP16, DPP8, DPP8FI and V_FMAMK_F32 come from the existing packages.
- One combinational sub-module, encode_vector_word, maps (latched record, in_vop3b, word kind) to a 32-bit dword. The top level holds the FSM, handshakes and output register.

Test Plan:
- VOP2, op=6'h01, vdst=8'h05, src1=8'h03, src0=9'h101, out_ready=1 -> one word 0x020A0701, out_last=1, in_ready high in the same cycle.
- VOP1, op=8'h01, vdst=0, src0={0,LITERAL_CONSTANT}, literal=0xDEADBEEF -> word0 bits[31:25]=7'h3F, bits[16:9]=8'h01, then 0xDEADBEEF with out_last=1.
- VOP3, op=10'h140, vdst=2, src0/1/2=9'h101/102/103, other fields 0 -> 0xD5400002 then 0x040E0501 (last).
- Same VOP3 with out_ready held low for 3 cycles after word0 -> out_data stays 0xD5400002 and in_ready=0 throughout; word1 follows once out_ready rises.
- VOPC with src0=SDWA, sd=1, sdst=7'h6A -> second word bits[15:8]=8'hEA; VOP2 with src0=DPP8 and lane_sel0..7=0..7 -> second word bits[31:8]=0xFAC688.
- Reset asserted while in E_WORD1 -> next cycle out_valid=0, busy=0, in_ready=1; the next accepted instruction emits correctly from word0.

Source files
------------

// File: rtl/encode_vector_pkg.sv
// Vector instruction record, ISA encoding constants and FSM/word-kind types
// shared by the vector encoder.
package encode_vector_pkg;

  localparam logic [7:0] LITERAL_CONSTANT = 8'hFF;
  localparam logic [8:0] SDWA             = 9'h0F9;
  localparam logic [8:0] DPP16            = 9'h0FA;
  localparam logic [8:0] DPP8             = 9'h0E9;
  localparam logic [8:0] DPP8FI           = 9'h0EA;
  localparam logic [9:0] V_FMAMK_F32      = 10'h02C;

  localparam logic [6:0] VOP1_PREFIX = 7'b0111111;
  localparam logic [6:0] VOPC_PREFIX = 7'b0111110;
  localparam logic [5:0] VINTRP_ENC  = 6'b110010;
  localparam logic [5:0] VOP3_ENC    = 6'b110101;
  localparam logic [5:0] VOP3P_ENC   = 6'b110011;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_VOP1, FMT_VOP2, FMT_VOPC, FMT_VINTRP, FMT_VOP3, FMT_VOP3P
  } vector_fmt_e;

  typedef struct packed {
    logic       s0, s1, sd;
    logic       src0_abs, src0_neg, src0_sext;
    logic       src1_abs, src1_neg, src1_sext;
    logic [2:0] src0_sel, src1_sel, dst_sel;
    logic [1:0] dst_u, omod;
    logic       clmp;
    logic [6:0] sdst;
    logic [7:0] src0;
  } sdwa_t;

  typedef struct packed {
    logic [3:0]      row_mask, bank_mask;
    logic            src1_abs, src1_neg, src0_abs, src0_neg;
    logic            bc, fi;
    logic [8:0]      dpp_ctrl;
    logic [7:0][2:0] lane_sel;
    logic [7:0]      src0;
  } dpp_t;

  typedef struct packed {
    vector_fmt_e fmt;
    logic [9:0]  op;
    logic [7:0]  vdst;
    logic [8:0]  src0, src1, src2;
    logic [6:0]  sdst;
    logic        clmp;
    logic [3:0]  op_sel;
    logic [2:0]  op_sel_hi, abs, neg, neg_hi;
    logic [1:0]  omod;
    logic [5:0]  attr;
    logic [1:0]  attr_chan;
    logic [31:0] literal;
    sdwa_t       sdwa;
    dpp_t        dpp;
  } vector_inst_t;

  typedef enum logic [2:0] {
    E_IDLE, E_WORD0, E_WORD1, E_SDWA, E_DPP, E_LITERAL
  } enc_state_e;

  typedef enum logic [2:0] {
    K_WORD0, K_WORD1, K_SDWA, K_DPP, K_LITERAL
  } enc_word_e;

  // Successor of state s for record r; E_IDLE means s emits the last word.
  function automatic enc_state_e enc_next(enc_state_e s, vector_inst_t r);
    enc_state_e n;
    logic lit0;
    n    = E_IDLE;
    lit0 = (r.src0 == {1'b0, LITERAL_CONSTANT});
    case (s)
      E_WORD0:
        case (r.fmt)
          FMT_VOP3, FMT_VOP3P: n = E_WORD1;
          FMT_VOP1, FMT_VOP2, FMT_VOPC:
            if (r.src0 == SDWA) n = E_SDWA;
            else if (r.src0 == DPP16 || r.src0 == DPP8 || r.src0 == DPP8FI) n = E_DPP;
            else if (lit0 || (r.fmt == FMT_VOP2 && r.op == V_FMAMK_F32)) n = E_LITERAL;
            else n = E_IDLE;
          default: n = E_IDLE;
        endcase
      E_WORD1:
        if (lit0 || r.src1 == {1'b0, LITERAL_CONSTANT} || r.src2 == {1'b0, LITERAL_CONSTANT})
          n = E_LITERAL;
      default: n = E_IDLE;
    endcase
    return n;
  endfunction

  function automatic enc_word_e state_kind(enc_state_e s);
    case (s)
      E_WORD1:   return K_WORD1;
      E_SDWA:    return K_SDWA;
      E_DPP:     return K_DPP;
      E_LITERAL: return K_LITERAL;
      default:   return K_WORD0;
    endcase
  endfunction

endpackage

// File: rtl/encode_vector_word.sv
// Combinational dword formatter: one record plus word kind to one ISA dword.
module encode_vector_word
  import encode_vector_pkg::*;
(
  input  vector_inst_t rec,
  input  logic         vop3b,
  input  enc_word_e    kind,
  output logic [31:0]  word
);

  always_comb begin
    word = '0;
    case (kind)
      K_WORD0:
        case (rec.fmt)
          FMT_VOP2:   word = {1'b0, rec.op[5:0], rec.vdst, rec.src1[7:0], rec.src0};
          FMT_VOPC:   word = {VOPC_PREFIX, rec.op[7:0], rec.src1[7:0], rec.src0};
          FMT_VINTRP: word = {VINTRP_ENC, rec.vdst, rec.op[1:0], rec.attr,
                              rec.attr_chan, rec.src0[7:0]};
          FMT_VOP3:   word = {VOP3_ENC, rec.op, rec.clmp,
                              vop3b ? rec.sdst : {rec.op_sel, rec.abs}, rec.vdst};
          FMT_VOP3P:  word = {VOP3P_ENC, 3'b000, rec.op[6:0], rec.clmp, rec.op_sel_hi[2],
                              rec.op_sel[2:0], rec.neg_hi, rec.vdst};
          // VOP1 and anything unrecognised share the VOP1 layout
          default:    word = {VOP1_PREFIX, rec.vdst, rec.op[7:0], rec.src0};
        endcase
      K_WORD1:
        word = {rec.neg, (rec.fmt == FMT_VOP3) ? rec.omod : rec.op_sel_hi[1:0],
                rec.src2, rec.src1, rec.src0};
      K_SDWA: begin
        word[31:16] = {rec.sdwa.s1, 1'b0, rec.sdwa.src1_abs, rec.sdwa.src1_neg,
                       rec.sdwa.src1_sext, rec.sdwa.src1_sel,
                       rec.sdwa.s0, 1'b0, rec.sdwa.src0_abs, rec.sdwa.src0_neg,
                       rec.sdwa.src0_sext, rec.sdwa.src0_sel};
        word[15:8]  = (rec.fmt == FMT_VOPC) ? {rec.sdwa.sd, rec.sdwa.sdst}
                    : {rec.sdwa.omod, rec.sdwa.clmp, rec.sdwa.dst_u, rec.sdwa.dst_sel};
        word[7:0]   = rec.sdwa.src0;
      end
      K_DPP: begin
        if (rec.src0 == DPP16)
          word[31:8] = {rec.dpp.row_mask, rec.dpp.bank_mask, rec.dpp.src1_abs,
                        rec.dpp.src1_neg, rec.dpp.src0_abs, rec.dpp.src0_neg,
                        rec.dpp.bc, rec.dpp.fi, 1'b0, rec.dpp.dpp_ctrl};
        else
          word[31:8] = rec.dpp.lane_sel;
        word[7:0] = rec.dpp.src0;
      end
      K_LITERAL: word = rec.literal;
      default:   word = '0;
    endcase
  end

endmodule

// File: rtl/encode_vector.sv
// Vector instruction encoder: latches a decoded record and streams its
// 1-3 dwords out through a registered valid/ready port.
module encode_vector
  import encode_vector_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  vector_inst_t in_inst,
  input  logic         in_vop3b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  enc_state_e   state, nxt, succ;
  vector_inst_t rec, nrec;
  logic         vop3b, nvop3b;
  logic         take, accept, load;
  enc_word_e    kind;
  logic [31:0]  word;

  assign out_valid = (state != E_IDLE);
  assign busy      = (state != E_IDLE);
  assign take      = out_valid & out_ready;
  assign in_ready  = (state == E_IDLE) | (take & out_last);
  assign accept    = in_valid & in_ready;
  assign succ      = enc_next(state, rec);

  // The next word is formatted from the incoming record on accept so it can
  // be registered in the same cycle, giving back-to-back streaming.
  always_comb begin
    nxt    = state;
    nrec   = rec;
    nvop3b = vop3b;
    if (accept) begin
      nxt    = E_WORD0;
      nrec   = in_inst;
      nvop3b = in_vop3b;
    end else if (take) begin
      nxt = succ;
    end
  end

  assign load = accept | (take & (succ != E_IDLE));
  assign kind = state_kind(nxt);

  encode_vector_word u_word (
    .rec   (nrec),
    .vop3b (nvop3b),
    .kind  (kind),
    .word  (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= E_IDLE;
      rec      <= '0;
      vop3b    <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        rec   <= in_inst;
        vop3b <= in_vop3b;
      end
      if (load) begin
        out_data <= word;
        out_last <= (enc_next(nxt, nrec) == E_IDLE);
      end else if (take) begin
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encode_vector.sv
// Directed bench for encode_vector: expected dwords are queued when an
// instruction is sent and checked as the encoder hands each one over.
module tb_encode_vector;
  import encode_vector_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  vector_inst_t in_inst;
  logic         in_vop3b, in_valid, in_ready;
  logic [31:0]  out_data;
  logic         out_valid, out_ready, out_last, busy;

  int           vectors = 0;
  int           miscompares = 0;
  logic [32:0]  sb[$];
  logic         acc;
  vector_inst_t r;

  encode_vector dut (
    .clk       (clk),
    .reset     (reset),
    .in_inst   (in_inst),
    .in_vop3b  (in_vop3b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    sb.push_back({l, d});
  endtask

  // Called at the falling edge: scores any word handed over at the next rise.
  task automatic mon();
    logic [32:0] e;
    acc = in_valid & in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("extra_word", {31'b0, out_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("word", out_data, e[31:0]);
        chk("last", {31'b0, out_last}, {31'b0, e[32]});
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vector_inst_t ri, input logic b);
    in_inst  = ri;
    in_vop3b = b;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && (sb.size() != 0 || out_valid); i++) cycle();
    n = sb.size();
    chk("words_left", n, 32'd0);
    chk("idle_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; in_inst = '0; in_vop3b = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'b0, out_last},  32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_busy",      {31'b0, busy},      32'd0);
    reset = 1'b0;
    #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // VOP2 single word, in_ready high while the last word is taken
    r = '0; r.fmt = FMT_VOP2; r.op = 10'h01; r.vdst = 8'h05; r.src1 = 9'h003; r.src0 = 9'h101;
    push(32'h020A0701, 1'b1);
    send(r, 1'b0);
    @(negedge clk);
    chk("vop2_in_ready", {31'b0, in_ready}, 32'd1);
    chk("vop2_busy", {31'b0, busy}, 32'd1);
    mon();
    @(posedge clk); #1;
    drain();

    // VOP1 with literal, followed back-to-back by a VOP2
    r = '0; r.fmt = FMT_VOP1; r.op = 10'h01; r.src0 = 9'h0FF; r.literal = 32'hDEADBEEF;
    push(32'h7E0002FF, 1'b0); push(32'hDEADBEEF, 1'b1);
    send(r, 1'b0);
    r = '0; r.fmt = FMT_VOP2; r.op = 10'h01; r.vdst = 8'h05; r.src1 = 9'h003; r.src0 = 9'h101;
    push(32'h020A0701, 1'b1);
    send(r, 1'b0);
    drain();

    // VOP3 with consumer stalled on word0
    r = '0; r.fmt = FMT_VOP3; r.op = 10'h140; r.vdst = 8'h02;
    r.src0 = 9'h101; r.src1 = 9'h102; r.src2 = 9'h103;
    push(32'hD5400002, 1'b0); push(32'h040E0501, 1'b1);
    out_ready = 1'b0;
    send(r, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", out_data, 32'hD5400002);
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      mon();
      @(posedge clk); #1;
    end
    drain();

    // VOPC + SDWA
    r = '0; r.fmt = FMT_VOPC; r.op = 10'h10; r.src1 = 9'h005; r.src0 = SDWA;
    r.sdwa.sd = 1'b1; r.sdwa.sdst = 7'h6A; r.sdwa.src0 = 8'h22;
    push(32'h7C200AF9, 1'b0); push(32'h0000EA22, 1'b1);
    send(r, 1'b0);
    drain();

    // VOP2 + DPP8 lane selects
    r = '0; r.fmt = FMT_VOP2; r.op = 10'h03; r.vdst = 8'h01; r.src1 = 9'h002; r.src0 = DPP8;
    r.dpp.src0 = 8'h44;
    for (int i = 0; i < 8; i++) r.dpp.lane_sel[i] = 3'(i);
    push(32'h060204E9, 1'b0); push(32'hFAC68844, 1'b1);
    send(r, 1'b0);
    drain();

    // VOP1 + DPP16
    r = '0; r.fmt = FMT_VOP1; r.op = 10'h02; r.vdst = 8'h03; r.src0 = DPP16;
    r.dpp.row_mask = 4'hF; r.dpp.bank_mask = 4'hA; r.dpp.src0_neg = 1'b1;
    r.dpp.bc = 1'b1; r.dpp.dpp_ctrl = 9'h01B; r.dpp.src0 = 8'h55;
    push(32'h7E0604FA, 1'b0); push(32'hFA181B55, 1'b1);
    send(r, 1'b0);
    drain();

    // V_FMAMK_F32 always carries a literal
    r = '0; r.fmt = FMT_VOP2; r.op = V_FMAMK_F32; r.src0 = 9'h101; r.literal = 32'h12345678;
    push(32'h58000101, 1'b0); push(32'h12345678, 1'b1);
    send(r, 1'b0);
    drain();

    // VINTRP with src0 = 0xFF stays a single word
    r = '0; r.fmt = FMT_VINTRP; r.op = 10'h2; r.vdst = 8'h07; r.attr = 6'h21;
    r.attr_chan = 2'd3; r.src0 = 9'h0FF;
    push(32'hC81E87FF, 1'b1);
    send(r, 1'b0);
    drain();

    // VOP3P with literal in src1
    r = '0; r.fmt = FMT_VOP3P; r.op = 10'h0A; r.clmp = 1'b1; r.op_sel_hi = 3'b101;
    r.op_sel = 4'b0010; r.neg_hi = 3'b001; r.vdst = 8'h10; r.neg = 3'b100;
    r.src2 = 9'h100; r.src1 = 9'h0FF; r.src0 = 9'h105; r.literal = 32'hCAFEF00D;
    push(32'hCC0AD110, 1'b0); push(32'h8C01FF05, 1'b0); push(32'hCAFEF00D, 1'b1);
    send(r, 1'b0);
    drain();

    // VOP3b: sdst replaces {op_sel, abs}
    r = '0; r.fmt = FMT_VOP3; r.op = 10'h30F; r.sdst = 7'h6A; r.op_sel = 4'hF; r.abs = 3'h7;
    r.vdst = 8'hFF; r.src0 = 9'h080; r.src1 = 9'h0C1; r.src2 = 9'h1FF;
    r.neg = 3'b011; r.omod = 2'd2;
    push(32'hD70F6AFF, 1'b0); push(32'h77FD8280, 1'b1);
    send(r, 1'b1);
    drain();

    // Unrecognised format: VOP1 layout, single word even with literal src0
    r = '0; r.fmt = FMT_NONE; r.op = 10'h05; r.vdst = 8'h01; r.src0 = 9'h0FF;
    push(32'h7E020AFF, 1'b1);
    send(r, 1'b0);
    drain();

    // Reset while word1 is pending discards it
    r = '0; r.fmt = FMT_VOP3; r.op = 10'h140; r.vdst = 8'h02;
    r.src0 = 9'h101; r.src1 = 9'h102; r.src2 = 9'h103;
    push(32'hD5400002, 1'b0);
    out_ready = 1'b0;
    send(r, 1'b0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset = 1'b0;
    r = '0; r.fmt = FMT_VOP2; r.op = 10'h01; r.vdst = 8'h05; r.src1 = 9'h003; r.src0 = 9'h101;
    push(32'h020A0701, 1'b1);
    out_ready = 1'b1;
    send(r, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
